// File: rtl/proc9_pkg.sv
// Shared definitions for the 9-bit processor and its program feeder.
// The opcode constants are also used by the processor core.
package proc9_pkg;

  localparam int WORD_W = 9;

  localparam logic [2:0] OP_MV  = 3'b000;
  localparam logic [2:0] OP_MVI = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_ISSUE,
    ST_OPERAND,
    ST_WAIT,
    ST_ERR
  } feeder_state_e;

  function automatic logic [2:0] opcode_of(input logic [WORD_W-1:0] word);
    return word[WORD_W-1 -: 3];
  endfunction

endpackage

// File: rtl/proc9_prog_ram.sv
// Program store for the feeder: one synchronous write port and one
// combinational read port. Contents survive reset.
module proc9_prog_ram #(
  parameter int AW = 4,
  parameter int DW = proc9_pkg::WORD_W
) (
  input  logic          clock,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);
  import proc9_pkg::*;

  logic [DW-1:0] mem_q [2**AW];

  always_ff @(posedge clock) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/proc9_program_feeder.sv
// Feeds stored instruction words to the 9-bit processor, one Run pulse per
// instruction, supplying the MVI immediate and waiting for Done in between.
//
// state   | meaning
// IDLE    | not running; waits for Start with a nonzero length
// CHECK   | inspects mem[Pc]; faults if an MVI has no immediate word
// ISSUE   | DataOut = mem[Pc], Run = 1
// OPERAND | DataOut = mem[Pc+1] (MVI immediate); Done already accepted
// WAIT    | waits for Done, bounded by TIMEOUT
// ERR     | faulted; Start restarts
module proc9_program_feeder #(
  parameter int         AW      = 4,
  parameter int         WORD_W  = proc9_pkg::WORD_W,
  parameter int         TIMEOUT = 15,
  parameter logic [2:0] MVI_OP  = proc9_pkg::OP_MVI
) (
  input  logic              clock,
  input  logic              Reset,
  input  logic              ProgWe,
  input  logic [AW-1:0]     ProgAddr,
  input  logic [WORD_W-1:0] ProgData,
  input  logic [AW:0]       ProgLen,
  input  logic              Start,
  input  logic              Done,
  output logic [WORD_W-1:0] DataOut,
  output logic              Run,
  output logic              Busy,
  output logic              Finished,
  output logic              Error,
  output logic [AW:0]       Pc
);
  import proc9_pkg::*;

  localparam int          CW        = $clog2(TIMEOUT + 1);
  localparam logic [CW:0] TIMEOUT_C = (CW+1)'(TIMEOUT);
  localparam logic [AW:0] DEPTH     = (AW+1)'(2**AW);

  feeder_state_e     state_q, state_d;
  logic [WORD_W-1:0] dout_q, dout_d;
  logic              run_q, run_d, busy_q, busy_d;
  logic              fin_q, fin_d, err_q, err_d, mvi_q, mvi_d;
  logic [AW:0]       pc_q, pc_d, len_q, len_d;
  logic [CW-1:0]     cnt_q, cnt_d;

  logic [AW+1:0]     pc_plus1, pc_adv;
  logic [AW-1:0]     raddr;
  logic [WORD_W-1:0] rdata;
  logic              word_mvi, timed_out;

  proc9_prog_ram #(.AW(AW), .DW(WORD_W)) u_ram (
    .clock (clock),
    .we    (ProgWe & ~busy_q),
    .waddr (ProgAddr),
    .wdata (ProgData),
    .raddr (raddr),
    .rdata (rdata)
  );

  // Extra bit keeps Pc+1 / Pc+2 comparisons against len free of wrap.
  assign pc_plus1  = {1'b0, pc_q} + 1'b1;
  assign pc_adv    = {1'b0, pc_q} + (mvi_q ? (AW+2)'(2) : (AW+2)'(1));
  assign raddr     = (state_q == ST_ISSUE) ? pc_plus1[AW-1:0] : pc_q[AW-1:0];
  assign word_mvi  = (opcode_of(rdata) == MVI_OP);
  assign timed_out = ({1'b0, cnt_q} + 1'b1) >= TIMEOUT_C;

  always_comb begin
    state_d = state_q;
    dout_d  = dout_q;
    run_d   = 1'b0;
    fin_d   = fin_q;
    err_d   = err_q;
    mvi_d   = mvi_q;
    pc_d    = pc_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE, ST_ERR: begin
        if (Start && (ProgLen != '0)) begin
          len_d   = (ProgLen > DEPTH) ? DEPTH : ProgLen;
          pc_d    = '0;
          fin_d   = 1'b0;
          err_d   = 1'b0;
          state_d = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (word_mvi && (pc_plus1 >= {1'b0, len_q})) begin
          err_d   = 1'b1;
          state_d = ST_ERR;
        end else begin
          dout_d  = rdata;
          run_d   = 1'b1;
          cnt_d   = '0;
          mvi_d   = word_mvi;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (mvi_q) begin
          dout_d  = rdata;
          state_d = ST_OPERAND;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_OPERAND, ST_WAIT: begin
        if (Done) begin
          pc_d = pc_adv[AW:0];
          if (pc_adv >= {1'b0, len_q}) begin
            fin_d   = 1'b1;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_CHECK;
          end
        end else if (timed_out) begin
          err_d   = 1'b1;
          state_d = ST_ERR;
        end else begin
          cnt_d   = cnt_q + 1'b1;
          state_d = ST_WAIT;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE) && (state_d != ST_ERR);
  end

  always_ff @(posedge clock) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      dout_q  <= '0;
      run_q   <= 1'b0;
      busy_q  <= 1'b0;
      fin_q   <= 1'b0;
      err_q   <= 1'b0;
      mvi_q   <= 1'b0;
      pc_q    <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      dout_q  <= dout_d;
      run_q   <= run_d;
      busy_q  <= busy_d;
      fin_q   <= fin_d;
      err_q   <= err_d;
      mvi_q   <= mvi_d;
      pc_q    <= pc_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
    end
  end

  assign DataOut  = dout_q;
  assign Run      = run_q;
  assign Busy     = busy_q;
  assign Finished = fin_q;
  assign Error    = err_q;
  assign Pc       = pc_q;

endmodule

// File: tb/tb_proc9_program_feeder.sv
// Directed bench for proc9_program_feeder: a per-program timing model predicts
// every output cycle by cycle from the start of each run.
module tb_proc9_program_feeder;

  localparam int AW   = 4;
  localparam int WW   = 9;
  localparam int MAXC = 128;

  logic          clock = 1'b0;
  logic          Reset, ProgWe, Start, Done;
  logic [AW-1:0] ProgAddr;
  logic [WW-1:0] ProgData;
  logic [AW:0]   ProgLen;
  logic [WW-1:0] DataOut;
  logic          Run, Busy, Finished, Error;
  logic [AW:0]   Pc;

  always #5 clock = ~clock;

  proc9_program_feeder #(.AW(AW), .WORD_W(WW), .TIMEOUT(15), .MVI_OP(3'b001)) dut (
    .clock    (clock),
    .Reset    (Reset),
    .ProgWe   (ProgWe),
    .ProgAddr (ProgAddr),
    .ProgData (ProgData),
    .ProgLen  (ProgLen),
    .Start    (Start),
    .Done     (Done),
    .DataOut  (DataOut),
    .Run      (Run),
    .Busy     (Busy),
    .Finished (Finished),
    .Error    (Error),
    .Pc       (Pc)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Model: program image plus the values the persistent outputs hold.
  logic [WW-1:0] mmem [16];
  int m_dout, m_pc, m_busy, m_fin, m_err;

  int e_dout [MAXC];
  int e_pc   [MAXC];
  bit e_run  [MAXC];
  bit e_busy [MAXC];
  bit e_fin  [MAXC];
  bit e_err  [MAXC];
  bit dsched [MAXC];

  function automatic void fill(input int idx);
    for (int i = idx; i < MAXC; i++) begin
      e_dout[i] = m_dout;
      e_pc[i]   = m_pc;
      e_busy[i] = (m_busy != 0);
      e_fin[i]  = (m_fin != 0);
      e_err[i]  = (m_err != 0);
    end
  endfunction

  // Cycle 0 is the Start cycle. dly = cycles from Run to Done (1..15 answers,
  // anything else means the processor never answers).
  function automatic void build_expect(input int len_in, input int dly);
    int len, c, w;
    bit mvi;
    for (int i = 0; i < MAXC; i++) begin
      e_run[i]  = 1'b0;
      dsched[i] = 1'b0;
    end
    m_busy = 0;
    fill(0);
    len    = (len_in > 16) ? 16 : len_in;
    m_busy = 1; m_pc = 0; m_fin = 0; m_err = 0;
    fill(1);
    c = 1;
    for (int it = 0; it < 20; it++) begin
      w   = int'(mmem[m_pc % 16]);
      mvi = ((w >> 6) == 1);
      if (mvi && (m_pc + 1 >= len)) begin
        m_busy = 0; m_err = 1;
        fill(c + 1);
        break;
      end
      m_dout = w;
      fill(c + 1);
      e_run[c + 1] = 1'b1;
      if (mvi) begin
        m_dout = int'(mmem[(m_pc + 1) % 16]);
        fill(c + 2);
      end
      if (dly >= 1 && dly <= 15) begin
        dsched[c + 1 + dly] = 1'b1;
        m_pc = m_pc + (mvi ? 2 : 1);
        if (m_pc >= len) begin
          m_busy = 0; m_fin = 1;
          fill(c + 2 + dly);
          break;
        end
        fill(c + 2 + dly);
        c = c + 2 + dly;
      end else begin
        m_busy = 0; m_err = 1;
        fill(c + 17);
        break;
      end
    end
  endfunction

  int            k;
  bit            active = 1'b0;
  int            runs_seen;
  logic [WW-1:0] run_words [$];

  always @(negedge clock) begin
    if (active) begin
      check($sformatf("k%0d Run", k),      Run,      e_run[k]);
      check($sformatf("k%0d Busy", k),     Busy,     e_busy[k]);
      check($sformatf("k%0d DataOut", k),  DataOut,  e_dout[k]);
      check($sformatf("k%0d Pc", k),       Pc,       e_pc[k]);
      check($sformatf("k%0d Finished", k), Finished, e_fin[k]);
      check($sformatf("k%0d Error", k),    Error,    e_err[k]);
      if (Run === 1'b1) begin
        runs_seen++;
        run_words.push_back(DataOut);
      end
    end
  end

  task automatic write_mem(input int addr, input int data);
    ProgWe   = 1'b1;
    ProgAddr = AW'(addr);
    ProgData = WW'(data);
    mmem[addr] = WW'(data);
    @(posedge clock); #1;
    ProgWe = 1'b0;
  endtask

  task automatic run_scen(input int len_in, input int dly, input int ncyc, input int we_at);
    build_expect(len_in, dly);
    runs_seen = 0;
    run_words.delete();
    @(posedge clock); #1;
    k = 0; active = 1'b1;
    Start = 1'b1; ProgLen = (AW+1)'(len_in); Done = dsched[0];
    for (int i = 1; i < ncyc; i++) begin
      @(posedge clock); #1;
      k = i;
      Start = 1'b0;
      Done  = dsched[i];
      if (i == we_at) begin
        ProgWe = 1'b1; ProgAddr = '0; ProgData = 9'h1FF;
      end else begin
        ProgWe = 1'b0;
      end
    end
    @(posedge clock); #1;
    active = 1'b0; Done = 1'b0; ProgWe = 1'b0;
  endtask

  task automatic check_hold(input string name);
    check({name, " Run"},      Run,      0);
    check({name, " Busy"},     Busy,     0);
    check({name, " DataOut"},  DataOut,  m_dout);
    check({name, " Pc"},       Pc,       m_pc);
    check({name, " Finished"}, Finished, m_fin);
    check({name, " Error"},    Error,    m_err);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset = 1'b1; ProgWe = 1'b0; Start = 1'b0; Done = 1'b0;
    ProgAddr = '0; ProgData = '0; ProgLen = '0;
    for (int i = 0; i < 16; i++) mmem[i] = '0;
    m_dout = 0; m_pc = 0; m_fin = 0; m_err = 0; m_busy = 0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check_hold("reset");
    @(posedge clock); #1;
    Reset = 1'b0;
    for (int i = 0; i < 16; i++) write_mem(i, 0);

    // Basic three-instruction program, Done two cycles after each Run.
    write_mem(0, 9'h008); write_mem(1, 9'h081); write_mem(2, 9'h0C2);
    run_scen(3, 2, 16, -1);
    check("basic runs", runs_seen, 3);
    if (run_words.size() == 3) begin
      check("basic word0", run_words[0], 9'h008);
      check("basic word1", run_words[1], 9'h081);
      check("basic word2", run_words[2], 9'h0C2);
    end
    check("basic Pc", Pc, 3);
    check("basic Finished", Finished, 1);

    // Done in IDLE and Start with zero length change nothing.
    Done = 1'b1;
    @(posedge clock); #1;
    Done = 1'b0;
    @(negedge clock);
    check_hold("idle_done");
    @(posedge clock); #1;
    Start = 1'b1; ProgLen = '0;
    @(posedge clock); #1;
    Start = 1'b0;
    @(negedge clock);
    check_hold("len0");
    @(posedge clock); #1;

    // MVI with Done accepted in the operand cycle.
    write_mem(0, 9'h040); write_mem(1, 9'h055);
    run_scen(2, 1, 8, -1);
    check("mvi runs", runs_seen, 1);
    if (run_words.size() == 1) check("mvi word0", run_words[0], 9'h040);
    check("mvi imm held", DataOut, 9'h055);
    check("mvi Pc", Pc, 2);

    // Timeout, then restart from ERR with Done on the last allowed cycle.
    write_mem(0, 9'h008);
    run_scen(1, 0, 22, -1);
    check("timeout Error", Error, 1);
    check("timeout runs", runs_seen, 1);
    run_scen(1, 15, 22, -1);
    check("late done Finished", Finished, 1);
    check("late done Error", Error, 0);

    // Truncated MVI faults without a Run.
    write_mem(0, 9'h040);
    run_scen(1, 1, 6, -1);
    check("trunc runs", runs_seen, 0);
    check("trunc Error", Error, 1);

    // Reset during WAIT of the basic program.
    write_mem(0, 9'h008); write_mem(1, 9'h081);
    run_scen(3, 0, 3, -1);
    Reset = 1'b1;
    @(posedge clock); #1;
    Reset = 1'b0;
    m_dout = 0; m_pc = 0; m_fin = 0; m_err = 0;
    @(negedge clock);
    check_hold("midreset");
    @(posedge clock); #1;

    // Rerun with a write attempt while busy, then once more.
    run_scen(3, 2, 16, 2);
    check("rerun runs", runs_seen, 3);
    run_scen(3, 2, 16, -1);
    if (run_words.size() == 3) check("rerun word0", run_words[0], 9'h008);

    // Length above the RAM depth runs all 16 words.
    for (int i = 0; i < 16; i++) write_mem(i, 9'h080 + i);
    run_scen(20, 1, 60, -1);
    check("clamp runs", runs_seen, 16);
    check("clamp Pc", Pc, 16);
    check("clamp Finished", Finished, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
